csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
Sequences machine-mode interrupt entry and MRET return for the three-stage pipeline.
- Watches timer and external interrupt lines, gated by CSR enables.
- Picks an instruction boundary in the Execute stage and squashes the Decode and Execute stages.
- Drives the CSR file's trap-write port (mepc, mcause, mstatus.MIE) and redirects the fetch PC.
- Sits beside the controller, between the CSR file and the PC/fetch logic.

Parameters:
XLEN, 32, datapath/PC width
MTVEC_ALIGN, 2, low mtvec bits forced to zero in direct mode

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
irq_timer  in  1  machine timer interrupt, level
irq_ext  in  1  machine external interrupt, level
mstatus_mie  in  1  global interrupt enable from CSR file
mie_mtie  in  1  timer enable
mie_meie  in  1  external enable
mtvec  in  XLEN  trap vector CSR
mepc  in  XLEN  current mepc CSR (MRET target)
pc_E  in  XLEN  PC of instruction in Execute
instr_valid_E  in  1  Execute holds a real (non-bubble) instruction
is_mret_E  in  1  Execute instruction is MRET
stall_in  in  1  pipeline stalled this cycle
flush_D  out  1  squash Decode
flush_E  out  1  squash Execute
pc_redirect  out  1  load redirect_pc into PC
redirect_pc  out  XLEN  redirect target
csr_trap_wr  out  1  write mepc/mcause this cycle
mepc_wr_data  out  XLEN  value for mepc
mcause_wr_data  out  XLEN  value for mcause
mstatus_mie_clr  out  1  clear MIE (MPIE<=MIE)
mstatus_mie_set  out  1  set MIE from MPIE (MRET)
busy  out  1  FSM not in IDLE

Behaviour:
- pending = mstatus_mie & ((irq_ext & mie_meie) | (irq_timer & mie_mtie)).
- Cause priority: external over timer.
  - External: mcause 0x8000_000B.
  - Timer: mcause 0x8000_0007.
- States: IDLE, WAIT_BND, TRAP, MRET_RET.
- State register is clocked; all outputs are Moore, decoded from the state and the captured registers.
- Reset (async): state=IDLE; captured PC/cause = 0; all outputs 0.
- IDLE transitions:
  - is_mret_E & instr_valid_E & !stall_in -> MRET_RET. MRET wins over a same-cycle pending interrupt.
  - Else if pending -> WAIT_BND.
- WAIT_BND:
  - pending=0 (e.g. CSR cleared the enable) -> IDLE with no side effects.
  - instr_valid_E & !stall_in -> capture pc_E and the cause sampled this cycle, then -> TRAP.
  - Otherwise hold.
- TRAP, exactly one cycle:
  - Assert csr_trap_wr, mstatus_mie_clr, flush_D, flush_E and pc_redirect.
  - mepc_wr_data = captured PC; the Execute instruction is squashed and re-executes after return.
  - redirect_pc = {mtvec[XLEN-1:2], 2'b00}.
  - Next state IDLE.
- MRET_RET, exactly one cycle:
  - Assert flush_D, flush_E, pc_redirect and mstatus_mie_set.
  - redirect_pc = mepc.
  - Next state IDLE.
- busy=1 in every state except IDLE.
- Latency: pending with a valid, unstalled Execute gives redirect 2 cycles after pending is sampled.
- Stall during TRAP/MRET_RET is ignored; the pulses still fire once. The PC/CSR logic gives redirect priority over stall.
- A cause change during WAIT_BND is allowed; the cause sampled on the capture cycle is the one recorded.
- Reset mid-sequence aborts with no CSR write; no pulse is ever longer than one cycle.

Optional Feature:
VECTORED_TRAP_EN
- Defined: when mtvec[1:0]==2'b01, redirect_pc in TRAP = {mtvec[XLEN-1:2],2'b00} + 4*cause_code (external 11 -> +0x2C, timer 7 -> +0x1C).
- Undefined: always direct mode; mtvec[1:0] ignored.

Decomposition:
- Package trap_pkg holds:
  - state enum trap_state_t (IDLE, WAIT_BND, TRAP, MRET_RET).
  - Constants MCAUSE_MEI = 32'h8000_000B and MCAUSE_MTI = 32'h8000_0007.
  - Cause codes CAUSE_MEI = 11 and CAUSE_MTI = 7.
  - MODE_VECTORED = 2'b01.
- No sub-module. Priority encoding and target computation are small enough to stay inline.

Test Plan:
1. Reset asserted mid-WAIT_BND -> state IDLE and all outputs 0 immediately (async); no csr_trap_wr afterward.
2. irq_timer=1, mtie=1, mie=1, pc_E=0x100 valid, mtvec=0x200 -> TRAP two cycles later: mepc_wr_data=0x100, mcause=0x8000_0007, redirect_pc=0x200, one-cycle pulses.
3. irq_ext and irq_timer both high, stall_in held 3 cycles -> stays WAIT_BND; trap fires after stall drops with mcause=0x8000_000B.
4. Pending raised, then mstatus_mie=0 while in WAIT_BND -> returns to IDLE; no flush, no redirect.
5. is_mret_E with pending interrupt in same cycle, mepc=0x104 -> MRET_RET first: redirect_pc=0x104, mie_set; interrupt entered afterward.
6. VECTORED_TRAP_EN defined, mtvec=0x201, irq_ext -> redirect_pc=0x22C. Undefined build with the same stimulus -> redirect_pc=0x200.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// trap_pkg: shared types and constants for csr_trap_ctrl.
//   trap_state_t  - trap sequencer state encoding
//   MCAUSE_*      - full mcause values written on interrupt entry
//   CAUSE_*       - interrupt cause codes (vector-table index)
//   MODE_VECTORED - mtvec[1:0] encoding selecting vectored dispatch
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BND = 2'd1,
        TRAP     = 2'd2,
        MRET_RET = 2'd3
    } trap_state_t;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;

    localparam int unsigned CAUSE_MEI = 11;
    localparam int unsigned CAUSE_MTI = 7;

    localparam logic [1:0] MODE_VECTORED = 2'b01;

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: groups the interrupt, CSR and pipeline signals seen by
// csr_trap_ctrl.
//   slave  modport - used by csr_trap_ctrl (consumes irq/CSR/pipeline state,
//                    drives flush, redirect and CSR trap-write controls)
//   master modport - used by the surrounding pipeline / CSR file
interface csr_trap_ctrl_if #(
    parameter int unsigned XLEN = 32
);

    logic            irq_timer;
    logic            irq_ext;
    logic            mstatus_mie;
    logic            mie_mtie;
    logic            mie_meie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] pc_E;
    logic            instr_valid_E;
    logic            is_mret_E;
    logic            stall_in;

    logic            flush_D;
    logic            flush_E;
    logic            pc_redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            csr_trap_wr;
    logic [XLEN-1:0] mepc_wr_data;
    logic [XLEN-1:0] mcause_wr_data;
    logic            mstatus_mie_clr;
    logic            mstatus_mie_set;
    logic            busy;

    modport slave (
        input  irq_timer, irq_ext, mstatus_mie, mie_mtie, mie_meie,
        input  mtvec, mepc, pc_E, instr_valid_E, is_mret_E, stall_in,
        output flush_D, flush_E, pc_redirect, redirect_pc, csr_trap_wr,
        output mepc_wr_data, mcause_wr_data, mstatus_mie_clr,
        output mstatus_mie_set, busy
    );

    modport master (
        output irq_timer, irq_ext, mstatus_mie, mie_mtie, mie_meie,
        output mtvec, mepc, pc_E, instr_valid_E, is_mret_E, stall_in,
        input  flush_D, flush_E, pc_redirect, redirect_pc, csr_trap_wr,
        input  mepc_wr_data, mcause_wr_data, mstatus_mie_clr,
        input  mstatus_mie_set, busy
    );

endinterface

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode interrupt entry and MRET return sequencer for
// the three-stage pipeline.
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - csr_trap_ctrl_if.slave: interrupt lines and enables, mtvec/mepc,
//           Execute-stage PC/valid/MRET/stall in; flushes, PC redirect,
//           mepc/mcause trap write and mstatus.MIE clear/set out, busy.
// All outputs are Moore: decoded from the state and captured PC/cause.
// Build option: define VECTORED_TRAP_EN to honour vectored mtvec mode
// (mtvec[1:0]==01 -> base + 4*cause_code); otherwise direct mode only.
module csr_trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MTVEC_ALIGN = 2
) (
    input logic             clk,
    input logic             reset,
    csr_trap_ctrl_if.slave  bus
);

    trap_state_t     state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;

    logic            ext_req;
    logic            pending;
    logic [XLEN-1:0] cause_now;
    logic            capture;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    assign ext_req   = bus.irq_ext & bus.mie_meie;
    assign pending   = bus.mstatus_mie & (ext_req | (bus.irq_timer & bus.mie_mtie));
    // External has priority over timer.
    assign cause_now = ext_req ? XLEN'(MCAUSE_MEI) : XLEN'(MCAUSE_MTI);
    assign trap_base = {bus.mtvec[XLEN-1:MTVEC_ALIGN], {MTVEC_ALIGN{1'b0}}};

`ifdef VECTORED_TRAP_EN
    logic [XLEN-1:0] vec_off;
    assign vec_off     = (cause_q == XLEN'(MCAUSE_MEI)) ? XLEN'(CAUSE_MEI * 4)
                                                        : XLEN'(CAUSE_MTI * 4);
    assign trap_target = (bus.mtvec[1:0] == MODE_VECTORED) ? trap_base + vec_off
                                                           : trap_base;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^bus.mtvec[MTVEC_ALIGN-1:0];
    assign trap_target       = trap_base;
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                // MRET takes precedence over an interrupt pending in the same cycle.
                if (bus.is_mret_E && bus.instr_valid_E && !bus.stall_in)
                    state_d = MRET_RET;
                else if (pending)
                    state_d = WAIT_BND;
            end
            WAIT_BND: begin
                if (!pending) begin
                    state_d = IDLE;
                end else if (bus.instr_valid_E && !bus.stall_in) begin
                    state_d = TRAP;
                    capture = 1'b1;
                end
            end
            TRAP:     state_d = IDLE;
            MRET_RET: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                pc_q    <= bus.pc_E;
                cause_q <= cause_now;
            end
        end
    end

    always_comb begin
        bus.flush_D         = 1'b0;
        bus.flush_E         = 1'b0;
        bus.pc_redirect     = 1'b0;
        bus.redirect_pc     = '0;
        bus.csr_trap_wr     = 1'b0;
        bus.mepc_wr_data    = '0;
        bus.mcause_wr_data  = '0;
        bus.mstatus_mie_clr = 1'b0;
        bus.mstatus_mie_set = 1'b0;
        bus.busy            = (state_q != IDLE);
        case (state_q)
            TRAP: begin
                bus.flush_D         = 1'b1;
                bus.flush_E         = 1'b1;
                bus.pc_redirect     = 1'b1;
                bus.redirect_pc     = trap_target;
                bus.csr_trap_wr     = 1'b1;
                bus.mepc_wr_data    = pc_q;
                bus.mcause_wr_data  = cause_q;
                bus.mstatus_mie_clr = 1'b1;
            end
            MRET_RET: begin
                bus.flush_D         = 1'b1;
                bus.flush_E         = 1'b1;
                bus.pc_redirect     = 1'b1;
                bus.redirect_pc     = bus.mepc;
                bus.mstatus_mie_set = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   pulse_viol;
    logic prev_wr;
    logic prev_redir;

    csr_trap_ctrl_if #(.XLEN(32)) bus ();

    csr_trap_ctrl #(.XLEN(32), .MTVEC_ALIGN(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // No output pulse may stay high across two consecutive cycles.
    always @(negedge clk) begin
        if (reset) begin
            prev_wr    <= 1'b0;
            prev_redir <= 1'b0;
        end else begin
            if ((bus.csr_trap_wr && prev_wr) || (bus.pc_redirect && prev_redir))
                pulse_viol <= pulse_viol + 1;
            prev_wr    <= bus.csr_trap_wr;
            prev_redir <= bus.pc_redirect;
        end
    end

    typedef struct {
        string       name;
        logic        ext, tmr, mie, mtie, meie;
        logic [31:0] pc, mtvec;
        logic        exp_trap;
        logic [31:0] exp_cause, exp_redir;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.irq_timer     = 1'b0;
        bus.irq_ext       = 1'b0;
        bus.mstatus_mie   = 1'b1;
        bus.mie_mtie      = 1'b1;
        bus.mie_meie      = 1'b1;
        bus.mtvec         = 32'h200;
        bus.mepc          = 32'h0;
        bus.pc_E          = 32'h0;
        bus.instr_valid_E = 1'b0;
        bus.is_mret_E     = 1'b0;
        bus.stall_in      = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_busy"},  {31'd0, bus.busy}, 32'd0);
        chk({name, "_outs"},
            {24'd0, bus.flush_D, bus.flush_E, bus.pc_redirect, bus.csr_trap_wr,
             bus.mstatus_mie_clr, bus.mstatus_mie_set, 2'b00}, 32'd0);
        chk({name, "_redir_pc"}, bus.redirect_pc, 32'd0);
    endtask

    task automatic chk_trap(input string name, input logic [31:0] mepc_e,
                            input logic [31:0] cause_e, input logic [31:0] redir_e);
        chk({name, "_ctl"},
            {26'd0, bus.flush_D, bus.flush_E, bus.pc_redirect, bus.csr_trap_wr,
             bus.mstatus_mie_clr, bus.mstatus_mie_set}, 32'h3E);
        chk({name, "_mepc"},   bus.mepc_wr_data,   mepc_e);
        chk({name, "_mcause"}, bus.mcause_wr_data, cause_e);
        chk({name, "_redir"},  bus.redirect_pc,    redir_e);
    endtask

    logic [31:0] exp_vec;

    initial begin
        errors     = 0;
        checks     = 0;
        pulse_viol = 0;

        //         name         ext   tmr   mie   mtie  meie  pc       mtvec     trap  cause          redirect
        tbl[0] = '{"tmr_only",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200,  1'b1, 32'h8000_0007, 32'h200};
        tbl[1] = '{"ext_only",  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3FC, 32'h1000, 1'b1, 32'h8000_000B, 32'h1000};
        tbl[2] = '{"both_mode3",1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h080, 32'h203,  1'b1, 32'h8000_000B, 32'h200};
        tbl[3] = '{"masked_en", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h040, 32'h200,  1'b0, 32'h0,          32'h0};
        tbl[4] = '{"mie_off",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h040, 32'h200,  1'b0, 32'h0,          32'h0};
        tbl[5] = '{"ext_masked",1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0C8, 32'h400,  1'b1, 32'h8000_0007, 32'h400};

        idle_inputs();
        reset = 1'b1;
        #3;
        chk_quiet("reset");
        step();
        step();
        #3 reset = 1'b0;
        step();
        chk_quiet("post_reset");

        // Table: pending sampled, WAIT_BND one cycle, TRAP the next.
        for (int unsigned i = 0; i < 6; i++) begin
            bus.irq_ext       = tbl[i].ext;
            bus.irq_timer     = tbl[i].tmr;
            bus.mstatus_mie   = tbl[i].mie;
            bus.mie_mtie      = tbl[i].mtie;
            bus.mie_meie      = tbl[i].meie;
            bus.pc_E          = tbl[i].pc;
            bus.mtvec         = tbl[i].mtvec;
            bus.instr_valid_E = 1'b1;
            step();
            chk({tbl[i].name, "_busy1"}, {31'd0, bus.busy}, {31'd0, tbl[i].exp_trap});
            chk({tbl[i].name, "_nowr1"}, {31'd0, bus.csr_trap_wr}, 32'd0);
            step();
            if (tbl[i].exp_trap)
                chk_trap(tbl[i].name, tbl[i].pc, tbl[i].exp_cause, tbl[i].exp_redir);
            else
                chk_quiet(tbl[i].name);
            idle_inputs();
            bus.stall_in = 1'b1;   // stall in TRAP must not stretch it
            step();
            chk_quiet({tbl[i].name, "_after"});
            bus.stall_in = 1'b0;
        end

        // Async reset in WAIT_BND aborts without a CSR write.
        idle_inputs();
        bus.irq_timer = 1'b1;
        step();
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_quiet("rst_mid");
        bus.irq_timer = 1'b0;
        bus.instr_valid_E = 1'b1;
        step();
        #3 reset = 1'b0;
        step();
        chk_quiet("rst_mid_after1");
        step();
        chk_quiet("rst_mid_after2");

        // Stall holds WAIT_BND; both lines high -> external cause.
        idle_inputs();
        bus.irq_ext = 1'b1;
        bus.irq_timer = 1'b1;
        bus.pc_E = 32'h2A0;
        bus.instr_valid_E = 1'b1;
        bus.stall_in = 1'b1;
        step();
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            chk("stall_hold_busy", {31'd0, bus.busy}, 32'd1);
            chk("stall_hold_nowr", {31'd0, bus.csr_trap_wr}, 32'd0);
        end
        bus.stall_in = 1'b0;
        step();
        chk_trap("stall_trap", 32'h2A0, 32'h8000_000B, 32'h200);
        idle_inputs();
        step();

        // Enable cleared while waiting -> back to IDLE, no side effects.
        bus.irq_timer = 1'b1;
        step();
        chk("mie_drop_busy", {31'd0, bus.busy}, 32'd1);
        bus.mstatus_mie = 1'b0;
        bus.instr_valid_E = 1'b1;
        step();
        chk_quiet("mie_drop");
        step();
        chk_quiet("mie_drop2");
        idle_inputs();

        // MRET wins over a same-cycle interrupt; interrupt is taken afterwards.
        bus.irq_timer = 1'b1;
        bus.is_mret_E = 1'b1;
        bus.instr_valid_E = 1'b1;
        bus.mepc = 32'h104;
        bus.pc_E = 32'h050;
        step();
        chk("mret_ctl",
            {26'd0, bus.flush_D, bus.flush_E, bus.pc_redirect, bus.csr_trap_wr,
             bus.mstatus_mie_clr, bus.mstatus_mie_set}, 32'h39);
        chk("mret_redir", bus.redirect_pc, 32'h104);
        bus.is_mret_E = 1'b0;
        bus.pc_E = 32'h104;
        step();
        chk("mret_back_idle", {31'd0, bus.busy}, 32'd0);
        step();
        chk("mret_then_wait", {31'd0, bus.busy}, 32'd1);
        step();
        chk_trap("mret_then_trap", 32'h104, 32'h8000_0007, 32'h200);
        idle_inputs();
        step();

        // Vectored mtvec with external interrupt.
`ifdef VECTORED_TRAP_EN
        exp_vec = 32'h22C;
`else
        exp_vec = 32'h200;
`endif
        bus.irq_ext = 1'b1;
        bus.mtvec = 32'h201;
        bus.pc_E = 32'h3000;
        bus.instr_valid_E = 1'b1;
        step();
        step();
        chk_trap("vec_ext", 32'h3000, 32'h8000_000B, exp_vec);
        idle_inputs();
        step();
`ifdef VECTORED_TRAP_EN
        exp_vec = 32'h21C;
`else
        exp_vec = 32'h200;
`endif
        bus.irq_timer = 1'b1;
        bus.mtvec = 32'h201;
        bus.pc_E = 32'h3004;
        bus.instr_valid_E = 1'b1;
        step();
        step();
        chk_trap("vec_tmr", 32'h3004, 32'h8000_0007, exp_vec);
        idle_inputs();
        step();
        step();

        chk("pulse_len", pulse_viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
